// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register IDs and the memory-stage FSM encoding.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RRSP  = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    localparam int QWORD_BYTES = 8;

    typedef enum logic [1:0] {
        MEM_IDLE   = 2'd0,
        MEM_ACCESS = 2'd1,
        MEM_DONE   = 2'd2
    } mem_state_e;

    function automatic logic is_mem_write(input logic [3:0] ic);
        return (ic == IRMMOVQ) || (ic == ICALL) || (ic == IPUSHQ);
    endfunction

    function automatic logic is_mem_read(input logic [3:0] ic);
        return (ic == IMRMOVQ) || (ic == IRET) || (ic == IPOPQ);
    endfunction

endpackage

// File: rtl/dmem_bytes.sv
// Single-port byte RAM: synchronous write, combinational read, MEM_BYTES deep, no reset of contents.
module dmem_bytes #(
    parameter int MEM_BYTES = 1024,
    parameter int IDXW      = $clog2(MEM_BYTES)
) (
    input  logic            clk,
    input  logic            we_i,
    input  logic [IDXW-1:0] addr_i,
    input  logic [7:0]      wdata_i,
    output logic [7:0]      rdata_o
);

    logic [7:0] mem_q [MEM_BYTES];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/memory.sv
// Y86-64 SEQ memory stage: one quadword per op, one byte per cycle; done 9 edges after start (1 for no-op/error).
// start is only sampled while idle and is dropped otherwise; MEM_ALIGN_CHECK_EN turns unaligned accesses into errors.
module memory
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int AW        = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [3:0]    icode,
    input  logic [AW-1:0] valA,
    input  logic [AW-1:0] valE,
    input  logic [AW-1:0] valP,
    output logic [63:0]   valM,
    output logic          done,
    output logic          busy,
    output logic          mem_error
);

    localparam int IDXW = $clog2(MEM_BYTES);

    mem_state_e      state_q;
    logic [2:0]      cnt_q;
    logic            is_wr_q;
    logic [IDXW-1:0] addr_q;
    logic [63:0]     wdata_q;
    logic [63:0]     valM_q;
    logic            done_q;
    logic            busy_q;
    logic            mem_error_q;

    logic            is_wr_d;
    logic            is_mem_d;
    logic [AW-1:0]   addr_d;
    logic [AW-1:0]   wdata_d;
    logic            err_d;

    logic [IDXW-1:0] ram_addr;
    logic            ram_we;
    logic [7:0]      ram_rdata;

    always_comb begin
        is_wr_d  = is_mem_write(icode);
        is_mem_d = is_wr_d || is_mem_read(icode);
        addr_d   = ((icode == IRET) || (icode == IPOPQ)) ? valA : valE;
        wdata_d  = (icode == ICALL) ? valP : valA;
        // Full-width compare: a huge address must not wrap back into range.
        err_d    = is_mem_d && (addr_d > AW'(MEM_BYTES - QWORD_BYTES));
`ifdef MEM_ALIGN_CHECK_EN
        if (is_mem_d && (addr_d[2:0] != 3'd0)) begin
            err_d = 1'b1;
        end
`else
`endif
    end

    assign ram_addr = addr_q + IDXW'(cnt_q);
    assign ram_we   = (state_q == MEM_ACCESS) && is_wr_q && !rst;

    dmem_bytes #(
        .MEM_BYTES (MEM_BYTES),
        .IDXW      (IDXW)
    ) u_dmem (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (wdata_q[{cnt_q, 3'b000} +: 8]),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= MEM_IDLE;
            cnt_q       <= 3'd0;
            valM_q      <= 64'd0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            mem_error_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                MEM_IDLE: begin
                    if (start) begin
                        is_wr_q <= is_wr_d;
                        addr_q  <= addr_d[IDXW-1:0];
                        wdata_q <= wdata_d[63:0];
                        valM_q  <= 64'd0;
                        cnt_q   <= 3'd0;
                        busy_q  <= 1'b1;
                        mem_error_q <= err_d;
                        if (is_mem_d && !err_d) begin
                            state_q <= MEM_ACCESS;
                        end else begin
                            state_q <= MEM_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                MEM_ACCESS: begin
                    if (!is_wr_q) begin
                        valM_q[{cnt_q, 3'b000} +: 8] <= ram_rdata;
                    end
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_q <= MEM_DONE;
                        done_q  <= 1'b1;
                    end
                end
                MEM_DONE: begin
                    state_q <= MEM_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= MEM_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign valM      = valM_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign mem_error = mem_error_q;

endmodule

// File: tb/tb_memory.sv
// Scoreboard bench for the memory stage: byte-array reference model, directed cases then random ops.
module tb_memory;

    localparam int MEM_BYTES = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  icode;
    logic [63:0] valA, valE, valP;
    logic [63:0] valM;
    logic        done, busy, mem_error;

    always #5 clk = ~clk;

    memory #(.MEM_BYTES(MEM_BYTES), .AW(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .icode     (icode),
        .valA      (valA),
        .valE      (valE),
        .valP      (valP),
        .valM      (valM),
        .done      (done),
        .busy      (busy),
        .mem_error (mem_error)
    );

    typedef struct packed {
        logic [63:0] v;
        logic        e;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] model [MEM_BYTES];
    int         tests = 0;
    int         fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // Monitor: every done pulse is matched against the oldest expected result.
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: done pulsed with no outstanding op, valM=%h", valM);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("valM", valM, e.v);
                chk("mem_error", {63'd0, mem_error}, {63'd0, e.e});
            end
        end
    end

    // Reference: quadword semantics straight from the op classes; returns expected latency.
    function automatic int model_op(input logic [3:0] ic, input logic [63:0] a,
                                    input logic [63:0] e, input logic [63:0] p);
        bit          wr, rd, err;
        logic [63:0] addr, data;
        exp_t        x;
        int          lat;
        wr   = (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
        rd   = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
        addr = (ic == 4'h9 || ic == 4'hB) ? a : e;
        data = (ic == 4'h8) ? p : a;
        err  = (wr || rd) && (addr > 64'(MEM_BYTES - 8));
`ifdef MEM_ALIGN_CHECK_EN
        if ((wr || rd) && (addr % 8 != 0)) err = 1'b1;
`endif
        x.v = 64'd0;
        x.e = err;
        lat = 1;
        if (!err && wr) begin
            for (int k = 0; k < 8; k++) model[int'(addr[15:0]) + k] = data[8*k +: 8];
            lat = 9;
        end
        if (!err && rd) begin
            for (int k = 0; k < 8; k++) x.v[8*k +: 8] = model[int'(addr[15:0]) + k];
            lat = 9;
        end
        sb_q.push_back(x);
        return lat;
    endfunction

    // Called #1 after an edge with the DUT idle; returns #1 after the edge that leaves DONE.
    task automatic do_op(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                         input logic [63:0] p, input bit noise);
        int lat, n;
        lat   = model_op(ic, a, e, p);
        icode = ic; valA = a; valE = e; valP = p;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        icode = 4'($urandom); valA = rand64(); valE = rand64(); valP = rand64();
        n = 1;
        while (done !== 1'b1 && n < 20) begin
            if (noise) begin
                start = 1'($urandom);
                icode = 4'($urandom);
                valE  = 64'($urandom_range(0, MEM_BYTES - 8));
            end
            @(posedge clk); #1;
            n++;
        end
        if (noise) start = 1'b1;
        chk("latency", 64'(n), 64'(lat));
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_done", {63'd0, busy}, 64'd0);
        chk("done_one_cycle", {63'd0, done}, 64'd0);
    endtask

    initial begin
        logic [63:0] addr, a, e;
        logic [3:0]  ic;
        int          r;

        rst = 1'b1; start = 1'b0; icode = 4'h0;
        valA = 64'd0; valE = 64'd0; valP = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valM", valM, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_mem_error", {63'd0, mem_error}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Give every byte a known value so any later read is predictable.
        for (int q = 0; q <= MEM_BYTES - 8; q += 8)
            do_op(4'h4, rand64(), 64'(q), rand64(), 1'b0);

        do_op(4'h4, 64'h1122334455667788, 64'h10, 64'd0, 1'b0);
        do_op(4'h5, rand64(), 64'h10, 64'd0, 1'b0);
        do_op(4'h8, rand64(), 64'h1F8, 64'h40, 1'b0);
        do_op(4'h9, 64'h1F8, rand64(), 64'd0, 1'b0);
        do_op(4'h5, 64'd0, 64'(MEM_BYTES - 4), 64'd0, 1'b0);
        do_op(4'h5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 1'b0);
        do_op(4'hA, 64'hDEAD_BEEF_0000_0001, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 1'b0);
        do_op(4'h6, rand64(), 64'h10, rand64(), 1'b0);
        do_op(4'h4, 64'h0102030405060708, 64'h30, 64'd0, 1'b1);
        do_op(4'h5, 64'd0, 64'h30, 64'd0, 1'b0);
        do_op(4'h4, 64'hCAFE_F00D_1234_5678, 64'(MEM_BYTES - 8), 64'd0, 1'b0);
        do_op(4'hB, 64'(MEM_BYTES - 8), 64'd0, 64'd0, 1'b0);
        do_op(4'h5, 64'd0, 64'(MEM_BYTES - 7), 64'd0, 1'b0);
        do_op(4'h4, 64'h8877665544332211, 64'h13, 64'd0, 1'b0);
        do_op(4'h5, 64'd0, 64'h13, 64'd0, 1'b0);
        do_op(4'h5, 64'd0, 64'h10, 64'd0, 1'b0);

        // Reset lands on the edge that would write byte 3: bytes 0..2 stick, no done.
        icode = 4'h4; valE = 64'h20; valA = 64'hAABBCCDDEEFF0011; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model[32'h20] = 8'h11; model[32'h21] = 8'h00; model[32'h22] = 8'hFF;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_valM", valM, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        do_op(4'h5, 64'd0, 64'h20, 64'd0, 1'b0);
        do_op(4'hB, 64'h18, 64'd0, 64'd0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            ic = 4'($urandom);
            a  = rand64();
            e  = rand64();
            r  = int'($urandom % 100);
            if (r < 70)      addr = 64'($urandom_range(0, MEM_BYTES - 8));
            else if (r < 80) addr = 64'(MEM_BYTES - 8);
            else if (r < 88) addr = 64'(MEM_BYTES - 7 + int'($urandom % 8));
            else             addr = rand64() | 64'h1_0000;
            if ($urandom % 2 == 0) addr[2:0] = 3'd0;
            if (ic == 4'h9 || ic == 4'hB) a = addr;
            else e = addr;
            do_op(ic, a, e, rand64(), 1'($urandom));
        end

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/memory.md
Name: memory

Overview:
- Memory stage of the SEQ Y86-64 processor. Sits between execute and writeback, and produces valM for writeback.
- Owns a byte-wide data memory. Performs each 8-byte little-endian quadword access one byte per cycle under a start/done handshake.
- Drives a memory-error flag, which feeds status/stat logic.

Parameters:
- MEM_BYTES, 1024, data memory size in bytes (multiple of 8, ≥16).
- AW, 64, address width; addresses are valE/valA as-is.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- icode  in  4  instruction code (INOP..IPOPQ encodings).
- valA  in  64  rA value / stack pointer for popq/ret.
- valE  in  64  ALU result (address for rmmovq/mrmovq/pushq/call).
- valP  in  64  next PC (write data for call).
- valM  out  64  read result; held until the next accepted start.
- done  out  1  one-cycle pulse: operation complete, valM/mem_error valid.
- busy  out  1  high in ACCESS and DONE.
- mem_error  out  1  address error on the last operation; held like valM.

Behaviour:
- Reset: state=IDLE, valM=0, done=0, busy=0, mem_error=0, byte counter=0. Memory contents are not cleared.
- Op classes:
  - Write: rmmovq (addr=valE, data=valA), pushq (valE, valA), call (valE, valP).
  - Read: mrmovq (addr=valE), popq (valA), ret (valA).
  - All other icodes are no-ops.
- On an accepted start, latch icode, addr and wdata. Upstream may change its inputs afterwards.
- Range check: error if addr > MEM_BYTES-8, compared at full 64 bits with no wrap. Checked at accept.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE + start, memory op, in range → ACCESS; cnt=0; valM cleared to 0; mem_error=0.
  - IDLE + start, no-op → DONE; valM=0; mem_error=0.
  - IDLE + start, memory op, out of range → DONE; valM=0; mem_error=1; no memory access.
  - ACCESS: each cycle handles byte cnt at addr+cnt.
    - Write: mem[addr+cnt] = wdata[8*cnt+7 : 8*cnt].
    - Read: valM[8*cnt+7 : 8*cnt] = mem[addr+cnt].
    - cnt increments; after cnt=7 → DONE.
  - DONE: done=1 for exactly one cycle → IDLE.
- Latency, counting clock edges from the edge that samples start to the edge at which done rises: 9 for a memory op, 1 for a no-op or error.
- start while busy is ignored entirely, not queued.
- Back-to-back: start may be asserted during the DONE cycle, but is only sampled in IDLE. Minimum issue interval is 10 cycles for memory ops.
- Reset mid-ACCESS: the byte write on the reset edge is suppressed; earlier bytes stay written. FSM goes to IDLE and done never pulses for the aborted op.
- rst has priority over start on the same edge.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- Defined: a memory op with addr[2:0] != 0 is treated as an error, identical to out-of-range (mem_error=1, no access, done after 1 edge).
- Undefined: unaligned accesses proceed byte-wise normally.

Decomposition:
- Shared package y86_pkg: icode constants (INOP..IPOPQ), register IDs, memory FSM state enum, QWORD_BYTES=8.
- Sub-module dmem_bytes: single-port byte RAM with synchronous write, combinational read, MEM_BYTES deep.
- FSM and counter live in memory.

Test Plan:
- rmmovq, valE=0x10, valA=0x1122334455667788, start → done 9 edges later. Then mrmovq, valE=0x10 → valM=0x1122334455667788; mem[0x10]=0x88, mem[0x17]=0x11.
- call, valE=0x1F8, valP=0x40 → ret, valA=0x1F8 → valM=0x40, mem_error=0.
- mrmovq, valE=MEM_BYTES-4 → done after 1 edge, mem_error=1, valM=0, memory unchanged. Repeat with valE=0xFFFF_FFFF_FFFF_FFFC → same result (no wrap).
- opq start → done after 1 edge, valM=0, no memory write. Pulse start again during ACCESS of a prior rmmovq → ignored; exactly one done.
- rmmovq to 0x20 of 0xAABBCCDDEEFF0011, rst on the edge writing byte 3 → bytes 0x20–0x22 = 11,00,FF; 0x23 unchanged; done never asserts; busy=0 next cycle.
- MEM_ALIGN_CHECK_EN defined: rmmovq, valE=0x13 → mem_error=1 after 1 edge. Undefined: succeeds with 9-edge latency.
